// File: rtl/data_ram_responder_if.sv
// Data-memory bus between the CPU MEM stage (master) and the data RAM
// responder (slave).
//   ce        request valid from the MEM stage
//   we        1 = store, 0 = load
//   addr      byte address (word index in addr[ADDR_WIDTH+1:2])
//   sel       big-endian byte enables, sel[3] -> data[31:24]
//   data_i    store data
//   data_o    load data, valid in the ack cycle and held until the next read ack
//   ack       single-cycle completion pulse
//   err       out-of-range flag, asserted together with ack
//   stall_req pipeline freeze request (combinational)
interface data_ram_responder_if;
  logic        ce;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        ack;
  logic        err;
  logic        stall_req;

  modport master (
    output ce, we, addr, sel, data_i,
    input  data_o, ack, err, stall_req
  );

  modport slave (
    input  ce, we, addr, sel, data_i,
    output data_o, ack, err, stall_req
  );
endinterface

// File: rtl/data_ram_responder.sv
// Word-organised data memory answering the CPU MEM-stage load/store port.
// A request is latched in IDLE, held for WAIT_CYCLES wait states, and
// completed in a single RESP cycle that pulses ack (and err when the latched
// address lies outside the array).
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   bus  data-memory bus, slave side (see data_ram_responder_if)
// Parameters:
//   ADDR_WIDTH   word-address bits, depth = 2**ADDR_WIDTH 32-bit words
//   WAIT_CYCLES  wait states between capture and response, 0..15
module data_ram_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  data_ram_responder_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int         DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  // Expand big-endian byte enables into a 32-bit lane mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  // Any address bit above the word index makes the access out of range.
  function automatic logic out_of_range(input logic [31:0] a);
    return (a >> (ADDR_WIDTH + 2)) != 32'd0;
  endfunction

  state_t      state;
  state_t      state_nx;
  logic [3:0]  wait_cnt;

  logic        req_we_p0;
  logic [31:0] req_addr_p0;
  logic [3:0]  req_sel_p0;
  logic [31:0] req_data_p0;

  logic [31:0] mem [DEPTH];

  logic        ack_q;
  logic        err_q;
  logic [31:0] data_q;

  logic        capture;
  logic        enter_resp;
  logic        commit;
  logic        nx_we;
  logic [31:0] nx_addr;
  logic [3:0]  nx_sel;
  logic        nx_oor;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic. Dropping ce during WAIT abandons the access.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (bus.ce) begin
          if (WAIT_CYCLES == 0) state_nx = RESP;
          else                  state_nx = WAIT;
        end
      end
      WAIT: begin
        if (!bus.ce)                state_nx = IDLE;
        else if (wait_cnt == 4'd0)  state_nx = RESP;
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output / steering logic. ack and err are registered on entry to RESP, so
  // the request fields they depend on are taken from whatever the latch will
  // hold in RESP: the live bus when capturing with zero wait states, the
  // latched copy otherwise.
  always_comb begin
    capture    = (state == IDLE) && bus.ce;
    enter_resp = (state_nx == RESP);
    nx_we      = capture ? bus.we   : req_we_p0;
    nx_addr    = capture ? bus.addr : req_addr_p0;
    nx_sel     = capture ? bus.sel  : req_sel_p0;
    nx_oor     = out_of_range(nx_addr);
    commit     = (state == RESP) && req_we_p0 && !out_of_range(req_addr_p0) && !rst;
  end

  assign bus.stall_req = bus.ce & ~ack_q;
  assign bus.ack       = ack_q;
  assign bus.err       = err_q;
  assign bus.data_o    = data_q;

  // ---- p0: request capture and wait-state counter ----
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt    <= 4'd0;
      req_we_p0   <= 1'b0;
      req_addr_p0 <= 32'd0;
      req_sel_p0  <= 4'd0;
      req_data_p0 <= 32'd0;
    end else begin
      if (capture) begin
        req_we_p0   <= bus.we;
        req_addr_p0 <= bus.addr;
        req_sel_p0  <= bus.sel;
        req_data_p0 <= bus.data_i;
        wait_cnt    <= WAIT_INIT;
      end else if ((state == WAIT) && (wait_cnt != 4'd0)) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
    end
  end

  // ---- p1: response registers, loaded on the edge entering RESP ----
  // data_o only changes on a read ack; writes and aborts leave it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      data_q <= 32'd0;
    end else begin
      ack_q <= enter_resp;
      err_q <= enter_resp && nx_oor;
      if (enter_resp && !nx_we) begin
        data_q <= nx_oor ? 32'd0 : (mem[nx_addr[ADDR_WIDTH+1:2]] & lane_mask(nx_sel));
      end
    end
  end

  // ---- p1: byte-lane write, committed on the edge leaving RESP ----
  // The array is never cleared; a reset in the commit cycle drops the write.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (req_sel_p0[b]) begin
          mem[req_addr_p0[ADDR_WIDTH+1:2]][8*b +: 8] <= req_data_p0[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_ram_responder.sv
// Scoreboard bench for data_ram_responder. Three instances (WAIT_CYCLES = 1,
// 3 and 0) share the request inputs; only the selected one sees ce. The
// driver pushes the expected response per access, a negedge monitor pops it
// on every ack.
module tb_data_ram_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [3:0]  sel = 4'd0;
  logic [31:0] data_i = 32'd0;
  logic [1:0]  dut_sel = 2'd0;   // 0: W1, 1: W3, 2: W0

  always #5 clk = ~clk;

  data_ram_responder_if if_w1 ();
  data_ram_responder_if if_w3 ();
  data_ram_responder_if if_w0 ();

  assign if_w1.ce = ce && (dut_sel == 2'd0);
  assign if_w3.ce = ce && (dut_sel == 2'd1);
  assign if_w0.ce = ce && (dut_sel == 2'd2);
  assign if_w1.we = we;     assign if_w3.we = we;     assign if_w0.we = we;
  assign if_w1.addr = addr; assign if_w3.addr = addr; assign if_w0.addr = addr;
  assign if_w1.sel = sel;   assign if_w3.sel = sel;   assign if_w0.sel = sel;
  assign if_w1.data_i = data_i; assign if_w3.data_i = data_i; assign if_w0.data_i = data_i;

  data_ram_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(1)) u_w1 (.clk(clk), .rst(rst), .bus(if_w1.slave));
  data_ram_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(3)) u_w3 (.clk(clk), .rst(rst), .bus(if_w3.slave));
  data_ram_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) u_w0 (.clk(clk), .rst(rst), .bus(if_w0.slave));

  logic [2:0]  ack_vec;
  logic [2:0]  err_vec;
  logic [2:0]  stall_vec;
  logic [31:0] dat [3];
  logic        act_ack;
  logic        act_err;
  logic        act_stall;
  logic [31:0] act_data;

  always_comb begin
    ack_vec   = {if_w0.ack, if_w3.ack, if_w1.ack};
    err_vec   = {if_w0.err, if_w3.err, if_w1.err};
    stall_vec = {if_w0.stall_req, if_w3.stall_req, if_w1.stall_req};
    dat[0]    = if_w1.data_o;
    dat[1]    = if_w3.data_o;
    dat[2]    = if_w0.data_o;
    act_ack   = ack_vec[dut_sel];
    act_err   = err_vec[dut_sel];
    act_stall = stall_vec[dut_sel];
    act_data  = dat[dut_sel];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          dut;
    bit          rd;
    logic [31:0] data;
    bit          err;
    int          cycle;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (ack_vec[i] === 1'b1) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_ack: instance %0d acked with nothing outstanding (cycle %0d)", i, cyc);
        end else begin
          e = sb.pop_front();
          check("ack_instance", 32'(i), 32'(e.dut));
          check("ack_cycle", 32'(cyc), 32'(e.cycle));
          check("ack_err", 32'(err_vec[i]), 32'(e.err));
          if (e.rd) check("ack_data", dat[i], e.data);
        end
      end
    end
  end

  // Issue one access in the next cycle and wait for its ack; ce is left high
  // so a following access call lands in the cycle right after the ack.
  task automatic access(input bit w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, input bit exp_err,
                        input logic [31:0] exp_data, input int wc);
    int n;
    bit seen;
    exp_t e;
    @(posedge clk);
    #1;
    ce = 1'b1; we = w; addr = a; sel = s; data_i = d;
    n = cyc;
    e.dut = int'(dut_sel); e.rd = !w; e.data = exp_data; e.err = exp_err; e.cycle = n + 1 + wc;
    sb.push_back(e);
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (act_ack === 1'b1) begin
        seen = 1'b1;
        check("stall_in_ack", 32'(act_stall), 32'd0);
      end else begin
        check("stall_waiting", 32'(act_stall), 32'd1);
      end
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL ack_timeout: no ack for addr %h within 40 cycles", a);
      void'(sb.pop_back());
    end
  endtask

  task automatic idle(input int n);
    @(posedge clk);
    #1;
    ce = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_no_ack(input int n, input string name);
    repeat (n) begin
      @(negedge clk);
      check(name, 32'(act_ack), 32'd0);
    end
  endtask

  int t1;
  int t2;

  initial begin
    // Reset hold with ce toggling.
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      ce = (i % 2) == 0; we = 1'b1; addr = 32'h10; sel = 4'hF; data_i = 32'h0BAD0BAD;
      @(negedge clk);
      check("rst_ack", 32'(act_ack), 32'd0);
      check("rst_err", 32'(act_err), 32'd0);
      check("rst_data", act_data, 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0; ce = 1'b0;
    expect_no_ack(4, "post_rst_ack");

    // Full-word store/load, WAIT_CYCLES = 1.
    access(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0, 1);
    access(1'b0, 32'h10, 4'hF, 32'h0, 1'b0, 32'hDEADBEEF, 1);
    idle(3);
    check("load_held", act_data, 32'hDEADBEEF);

    // Byte-lane store; write acks leave data_o alone.
    access(1'b1, 32'h10, 4'b0100, 32'h00AA0000, 1'b0, 32'h0, 1);
    idle(1);
    check("data_after_write", act_data, 32'hDEADBEEF);
    access(1'b0, 32'h10, 4'hF, 32'h0, 1'b0, 32'hDEAABEEF, 1);
    access(1'b0, 32'h10, 4'b1000, 32'h0, 1'b0, 32'hDE000000, 1);

    // Out of range.
    access(1'b1, 32'h0, 4'hF, 32'h11223344, 1'b0, 32'h0, 1);
    access(1'b1, 32'h1000, 4'hF, 32'h12345678, 1'b1, 32'h0, 1);
    access(1'b0, 32'h0, 4'hF, 32'h0, 1'b0, 32'h11223344, 1);
    access(1'b0, 32'h1000, 4'hF, 32'h0, 1'b1, 32'h0, 1);

    // Empty byte enables.
    access(1'b0, 32'h10, 4'h0, 32'h0, 1'b0, 32'h0, 1);
    access(1'b1, 32'h0, 4'h0, 32'hFFFFFFFF, 1'b0, 32'h0, 1);
    access(1'b0, 32'h0, 4'hF, 32'h0, 1'b0, 32'h11223344, 1);

    // Reset during WAIT of a store discards it.
    access(1'b1, 32'h20, 4'hF, 32'hCAFEF00D, 1'b0, 32'h0, 1);
    idle(1);
    @(posedge clk);
    #1;
    ce = 1'b1; we = 1'b1; addr = 32'h20; sel = 4'hF; data_i = 32'h0BADBEEF;
    @(posedge clk);
    #1;
    rst = 1'b1; ce = 1'b0;
    @(negedge clk);
    check("rst_wait_ack", 32'(act_ack), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_wait_ack_late", 32'(act_ack), 32'd0);
    check("rst_wait_data", act_data, 32'd0);
    access(1'b0, 32'h20, 4'hF, 32'h0, 1'b0, 32'hCAFEF00D, 1);
    idle(1);

    // WAIT_CYCLES = 3: abort by dropping ce mid-WAIT.
    dut_sel = 2'd1;
    access(1'b1, 32'h30, 4'hF, 32'h55AA55AA, 1'b0, 32'h0, 3);
    idle(1);
    @(posedge clk);
    #1;
    ce = 1'b1; we = 1'b1; addr = 32'h30; sel = 4'hF; data_i = 32'h12121212;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    ce = 1'b0;
    expect_no_ack(6, "abort_ack");
    check("abort_data", act_data, 32'd0);
    access(1'b0, 32'h30, 4'hF, 32'h0, 1'b0, 32'h55AA55AA, 3);
    idle(1);

    // WAIT_CYCLES = 0: back-to-back loads.
    dut_sel = 2'd2;
    access(1'b1, 32'h40, 4'hF, 32'h01020304, 1'b0, 32'h0, 0);
    idle(1);
    access(1'b0, 32'h40, 4'hF, 32'h0, 1'b0, 32'h01020304, 0);
    t1 = cyc;
    access(1'b0, 32'h40, 4'b0011, 32'h0, 1'b0, 32'h00000304, 0);
    t2 = cyc;
    check("w0_spacing", 32'(t2 - t1), 32'd2);
    idle(3);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/data_ram_responder.md
Name: data_ram_responder

Overview:
- Word-organised data memory that answers the CPU's MEM-stage load/store port inside the minimal SOPC.
- It is the responder side of the CPU's data-memory initiator interface.
- Latches each request and inserts a configurable number of wait states, holding the pipeline with stall_req.
- Returns one ack pulse per completed access, with big-endian byte-lane writes and an out-of-range error flag.

Parameters:
ADDR_WIDTH, 10, word-address bits; depth = 2**ADDR_WIDTH 32-bit words.
WAIT_CYCLES, 1, wait states between request capture and response; legal range 0..15.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset (asserted value RST_ENABLE = 1).
ce  input  1  request valid from the CPU MEM stage.
we  input  1  1 = store, 0 = load.
addr  input  32  byte address; addr[1:0] ignored; word index = addr[ADDR_WIDTH+1:2].
sel  input  4  byte enables; sel[3] -> data[31:24] … sel[0] -> data[7:0] (big-endian).
data_i  input  32  store data.
data_o  output  32  load data; valid in the ack cycle, held until the next read ack.
ack  output  1  single-cycle completion pulse.
err  output  1  asserted with ack when the address is out of range.
stall_req  output  1  combinational; = ce & ~ack; tells the pipeline controller to freeze.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, wait counter=0, ack=0, err=0, data_o=0. Latched request registers are cleared. Memory array contents are not cleared. Any pending write is discarded, including a reset during WAIT.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If ce=1, latch addr, we, sel and data_i.
  - Go to WAIT with counter = WAIT_CYCLES-1 when WAIT_CYCLES>0; otherwise go to RESP.
  - If ce=0, stay in IDLE.
- WAIT:
  - Decrement the counter each cycle; go to RESP when the counter is 0.
  - If ce drops to 0 while in WAIT, abort to IDLE. No write, no ack.
- RESP (exactly one cycle):
  - ack=1.
  - Range check: out of range = latched addr[31:ADDR_WIDTH+2] != 0. Out of range gives err=1.
  - Write, in range: update only the bytes whose sel bit is 1, at this clock edge.
  - Read, in range: data_o = the stored word masked by sel (unselected bytes = 0).
  - Read, out of range: data_o=0. Out-of-range writes are dropped.
  - Next state is IDLE unconditionally.
- Latency: a request first seen in IDLE at cycle N is acked at cycle N+1+WAIT_CYCLES. stall_req is 1 from cycle N through N+WAIT_CYCLES and 0 in the ack cycle.
- Back-to-back accesses: the CPU presents the next request in the cycle after the ack, and it is captured in IDLE. Minimum spacing is 2+WAIT_CYCLES cycles per access.
- sel=4'b0000 with ce=1: normal ack; write changes nothing; read returns 0.
- Request inputs that change during WAIT are ignored; only the latched values are used.
- data_o is not modified by write acks or error-free aborts.
- Read-after-write to the same word returns the new value. The write commits at the RESP edge, before any later read can reach RESP.
- ack and err are registered outputs. stall_req is the only combinational output.

Test Plan:
- Reset hold: rst=1 for 20 cycles, with ce=1 toggling -> ack=0, err=0, data_o=0 throughout. After release, no spurious ack.
- Full-word store/load, WAIT_CYCLES=1:
  - Store addr=0x10, sel=4'hF, data_i=0xDEADBEEF -> ack at N+2, stall_req high at N and N+1.
  - Then load 0x10 -> data_o=0xDEADBEEF in the ack cycle, held afterwards.
- Byte-lane store: starting from word 0x10 = 0xDEADBEEF, store sel=4'b0100, data_i=0x00AA0000 -> a load of 0x10 returns 0xDEAABEEF. A load with sel=4'b1000 returns 0xDE000000.
- Out of range, ADDR_WIDTH=10: store 0x00001000 with 0x12345678 -> ack=1 and err=1. Memory word 0 is unchanged. A load of 0x00001000 returns 0 with err=1.
- Abort and reset mid-operation:
  - WAIT_CYCLES=3, drop ce during WAIT -> no ack, no write, returns to IDLE.
  - Assert rst during WAIT of a store to 0x20 -> a later load of 0x20 returns the old value.
- Zero wait: WAIT_CYCLES=0, two back-to-back loads -> each acked 1 cycle after capture, one access every 2 cycles, stall_req low only in the ack cycles.
